// File: rtl/remap_alloc_scheduler.sv
// remap_alloc_scheduler: sequences one logical-to-physical PE row allocation pass,
// reusing matched faulty rows and otherwise binding the lowest free healthy row.
module remap_alloc_scheduler #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     wt_req,
    output logic [ADDR_WIDTH-1:0]    wt_row_addr,
    input  logic                     wt_ack,
    input  logic [SYSTOLIC_SIZE-1:0] wt_zero_flags,
    output logic                     alloc_valid,
    output logic [SYSTOLIC_SIZE-1:0] alloc_zero_flags,
    output logic [ADDR_WIDTH-1:0]    alloc_row_addr,
    input  logic                     match_success,
    input  logic                     match_failed,
    input  logic [ADDR_WIDTH-1:0]    faulty_row_addr,
    input  logic [SYSTOLIC_SIZE-1:0] faulty_rows_mask,
    input  logic                     all_faulty_matched,
    output logic                     map_wr_en,
    output logic [ADDR_WIDTH-1:0]    map_logical_row,
    output logic [ADDR_WIDTH-1:0]    map_physical_row,
    output logic                     map_is_faulty,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [ADDR_WIDTH-1:0]    fail_row
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, RESOLVE, WRITE, DONE, FAIL} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d, phys_q, phys_d, lrow_q, lrow_d, frow_q, frow_d, low_idx;
    logic [SYSTOLIC_SIZE-1:0] flags_q, flags_d, used_q, used_d, fault_q, fault_d, free;
    logic is_f_q, is_f_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic req_q, req_d, av_q, av_d, wr_q, wr_d, res_err;
    always_comb begin
        free = ~fault_q & ~used_q;
        low_idx = '0;
        for (int i = SYSTOLIC_SIZE - 1; i >= 0; i--)
            if (free[i]) low_idx = ADDR_WIDTH'(i);
        // protocol error, reused faulty row, or no healthy row left
        res_err = (match_success == match_failed) ||
                  (match_success ? used_q[faulty_row_addr] : ~|free);
        state_d = state_q;
        row_d = row_q;
        flags_d = flags_q;
        used_d = used_q;
        fault_d = fault_q;
        phys_d = phys_q;
        lrow_d = lrow_q;
        is_f_d = is_f_q;
        frow_d = frow_q;
        busy_d = busy_q;
        done_d = done_q;
        fail_d = fail_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = FETCH;
                row_d = '0;
                used_d = '0;
                fault_d = faulty_rows_mask;
                done_d = 1'b0;
                fail_d = 1'b0;
                busy_d = 1'b1;
            end
            FETCH: if (wt_ack) begin
                flags_d = wt_zero_flags;
                state_d = ISSUE;
            end
            ISSUE: state_d = RESOLVE;
            RESOLVE: begin
                state_d = res_err ? FAIL : WRITE;
                frow_d = res_err ? row_q : frow_q;
                phys_d = match_success ? faulty_row_addr : low_idx;
                is_f_d = match_success;
                lrow_d = row_q;
            end
            WRITE: begin
                used_d[phys_q] = 1'b1;
                state_d = (row_q == LAST) ? DONE : FETCH;
                row_d = (row_q == LAST) ? row_q : row_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                busy_d = 1'b0;
                done_d = all_faulty_matched;
                fail_d = ~all_faulty_matched;
                frow_d = all_faulty_matched ? frow_q : LAST;
            end
            default: begin
                state_d = IDLE;
                busy_d = 1'b0;
                fail_d = 1'b1;
            end
        endcase
        req_d = state_d == FETCH;
        av_d = state_d == ISSUE;
        wr_d = state_d == WRITE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q <= '0;
            flags_q <= '0;
            used_q <= '0;
            fault_q <= '0;
            phys_q <= '0;
            lrow_q <= '0;
            is_f_q <= 1'b0;
            frow_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            fail_q <= 1'b0;
            req_q <= 1'b0;
            av_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q <= row_d;
            flags_q <= flags_d;
            used_q <= used_d;
            fault_q <= fault_d;
            phys_q <= phys_d;
            lrow_q <= lrow_d;
            is_f_q <= is_f_d;
            frow_q <= frow_d;
            busy_q <= busy_d;
            done_q <= done_d;
            fail_q <= fail_d;
            req_q <= req_d;
            av_q <= av_d;
            wr_q <= wr_d;
        end
    end
    assign wt_req = req_q;
    assign wt_row_addr = row_q;
    assign alloc_valid = av_q;
    assign alloc_zero_flags = flags_q;
    assign alloc_row_addr = row_q;
    assign map_wr_en = wr_q;
    assign map_logical_row = lrow_q;
    assign map_physical_row = phys_q;
    assign map_is_faulty = is_f_q;
    assign busy = busy_q;
    assign done = done_q;
    assign fail = fail_q;
    assign fail_row = frow_q;
endmodule

// File: tb/tb_remap_alloc_scheduler.sv
// tb_remap_alloc_scheduler: directed scenarios with a greedy allocation model and
// emulated weight buffer / faulty-row storage.
module tb_remap_alloc_scheduler;
    localparam int N = 8;
    localparam int AW = 3;
    logic clk = 0, rst = 1, start = 0;
    logic wt_req, wt_ack = 0, alloc_valid, match_success = 0, match_failed = 0;
    logic [AW-1:0] wt_row_addr, alloc_row_addr, faulty_row_addr = 0;
    logic [N-1:0] wt_zero_flags = 0, alloc_zero_flags, faulty_rows_mask = 0;
    logic all_faulty_matched = 1;
    logic map_wr_en, map_is_faulty, busy, done, fail;
    logic [AW-1:0] map_logical_row, map_physical_row, fail_row;

    remap_alloc_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .wt_req(wt_req), .wt_row_addr(wt_row_addr),
        .wt_ack(wt_ack), .wt_zero_flags(wt_zero_flags), .alloc_valid(alloc_valid),
        .alloc_zero_flags(alloc_zero_flags), .alloc_row_addr(alloc_row_addr),
        .match_success(match_success), .match_failed(match_failed),
        .faulty_row_addr(faulty_row_addr), .faulty_rows_mask(faulty_rows_mask),
        .all_faulty_matched(all_faulty_matched), .map_wr_en(map_wr_en),
        .map_logical_row(map_logical_row), .map_physical_row(map_physical_row),
        .map_is_faulty(map_is_faulty), .busy(busy), .done(done), .fail(fail),
        .fail_row(fail_row)
    );

    always #5 clk = ~clk;

    logic [N-1:0] flags [N];
    int resp [N];
    int saddr [N];
    int dly [N];
    int exp_phys [N];
    bit exp_flt [N];
    int m_nwr, m_nissue, m_frow, m_cyc;
    bit m_fail;
    int checks = 0, passes = 0;
    int wr_cnt = 0, av_cnt = 0, wcnt = 0;
    bit active = 0, last_req = 0, pend = 0;
    int prow = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    task automatic clear_cfg();
        for (int r = 0; r < N; r++) begin
            flags[r] = '0;
            resp[r] = 0;
            saddr[r] = 0;
            dly[r] = 0;
        end
        faulty_rows_mask = '0;
        all_faulty_matched = 1;
    endtask

    // Greedy allocation straight from the rules: reuse a matched faulty row once,
    // otherwise take the lowest healthy unused row.
    task automatic model();
        logic [N-1:0] used = '0;
        bit stop = 0;
        m_nwr = 0; m_nissue = 0; m_fail = 0; m_frow = 0; m_cyc = 1;
        for (int r = 0; r < N; r++) begin
            if (!stop) begin
                bit ok = 0, f = 0;
                int p = 0;
                m_nissue++;
                m_cyc += 3 + dly[r];
                if (resp[r] == 1 && !used[saddr[r]]) begin
                    p = saddr[r]; f = 1; ok = 1;
                end else if (resp[r] == 0) begin
                    for (int i = N - 1; i >= 0; i--)
                        if (!faulty_rows_mask[i] && !used[i]) begin p = i; ok = 1; end
                end
                if (ok) begin
                    exp_phys[m_nwr] = p; exp_flt[m_nwr] = f; m_nwr++; used[p] = 1'b1; m_cyc += 1;
                end else begin
                    stop = 1; m_fail = 1; m_frow = r;
                end
            end
        end
        if (!m_fail && !all_faulty_matched) begin m_fail = 1; m_frow = N - 1; end
    endtask

    always @(negedge clk) begin
        if (wt_req) begin
            wt_ack = (wcnt == dly[wt_row_addr]);
            wt_zero_flags = flags[wt_row_addr];
            wcnt++;
        end else begin
            wt_ack = 0;
            wcnt = 0;
        end
    end

    always @(negedge clk) begin
        match_success = 0;
        match_failed = 0;
        if (pend) begin
            match_success = resp[prow] == 1 || resp[prow] == 2;
            match_failed = resp[prow] == 0 || resp[prow] == 2;
            faulty_row_addr = AW'(saddr[prow]);
        end
        pend = alloc_valid;
        prow = int'(alloc_row_addr);
    end

    always @(posedge clk) begin
        #1;
        if (active && !rst) begin
            check("alloc_valid_timing", alloc_valid, last_req && wt_ack);
            if (alloc_valid) begin
                check("alloc_row", alloc_row_addr, av_cnt);
                check("alloc_flags", alloc_zero_flags, flags[av_cnt % N]);
                av_cnt++;
            end
            if (map_wr_en) begin
                if (wr_cnt < m_nwr) begin
                    check("map_logical", map_logical_row, wr_cnt);
                    check("map_physical", map_physical_row, exp_phys[wr_cnt]);
                    check("map_is_faulty", map_is_faulty, exp_flt[wr_cnt]);
                end else check("extra_write", 1, 0);
                wr_cnt++;
            end
        end
        last_req = wt_req;
    end

    task automatic run(input string name, input bit pulse, input int lit_cyc, input int lit_frow);
        int c = 0;
        model();
        check({name, "_model_cyc"}, m_cyc, lit_cyc);
        if (m_fail) check({name, "_model_frow"}, m_frow, lit_frow);
        wr_cnt = 0; av_cnt = 0; active = 1;
        @(negedge clk) start = 1;
        @(posedge clk);
        #1 start = 0;
        while (c < 300) begin
            @(posedge clk);
            c++;
            #1;
            start = pulse && (c == 10);
            if (done || fail) break;
        end
        start = 0;
        check({name, "_cycles"}, c, m_cyc);
        check({name, "_done"}, done, !m_fail);
        check({name, "_fail"}, fail, m_fail);
        if (m_fail) check({name, "_fail_row"}, fail_row, m_frow);
        check({name, "_writes"}, wr_cnt, m_nwr);
        check({name, "_issues"}, av_cnt, m_nissue);
        check({name, "_busy"}, busy, 0);
        active = 0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int c;
        clear_cfg();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {wt_req, wt_row_addr, alloc_valid, alloc_zero_flags, alloc_row_addr,
              map_wr_en, map_logical_row, map_physical_row, map_is_faulty, busy, done, fail, fail_row}, 0);
        @(negedge clk) rst = 0;

        run("no_faults", 1, 33, 0);

        clear_cfg();
        faulty_rows_mask = 8'b0000_1000;
        flags[0] = 8'hFF; resp[0] = 1; saddr[0] = 3;
        model();
        check("s2_model_row0", exp_phys[0], 3);
        check("s2_model_row4", exp_phys[4], 4);
        check("s2_model_row3", exp_phys[3], 2);
        run("row3_faulty", 0, 33, 0);

        clear_cfg();
        faulty_rows_mask = 8'b0010_0100;
        flags[0] = 8'h0F; resp[0] = 1; saddr[0] = 2;
        run("rows25_faulty", 0, 32, 7);

        clear_cfg();
        dly[4] = 3;
        run("ack_delay", 0, 36, 0);

        clear_cfg();
        resp[2] = 2;
        run("protocol_both", 0, 12, 2);

        clear_cfg();
        resp[1] = 3;
        run("protocol_none", 0, 8, 1);

        clear_cfg();
        resp[1] = 1; saddr[1] = 0;
        run("reused_row", 0, 8, 1);

        clear_cfg();
        all_faulty_matched = 0;
        run("unmatched_faults", 0, 33, 7);

        clear_cfg();
        for (int r = 0; r < N; r++) flags[r] = 8'h11 * r[7:0];
        model();
        wr_cnt = 0; av_cnt = 0; active = 1;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        c = 0;
        while (c < 100 && !(alloc_valid && alloc_row_addr == 5)) begin
            @(posedge clk);
            #1 c++;
        end
        check("reset_reach_row5", c < 100, 1);
        @(negedge clk) rst = 1;
        @(posedge clk);
        #1;
        check("midpass_reset_outputs", {wt_req, wt_row_addr, alloc_valid, alloc_zero_flags, alloc_row_addr,
              map_wr_en, map_logical_row, map_physical_row, map_is_faulty, busy, done, fail, fail_row}, 0);
        @(negedge clk) rst = 0;
        repeat (10) @(posedge clk);
        #1;
        check("midpass_reset_writes", wr_cnt, 5);
        check("midpass_reset_idle", busy, 0);
        active = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
